prescaled_counter: RTL and testbench



---
 rtl/prescaled_counter_pkg.sv | 13 +
 rtl/prescaled_counter_prescaler_tick.sv | 31 +++
 rtl/prescaled_counter.sv | 106 ++++++++++
 tb/tb_prescaled_counter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prescaled_counter_pkg.sv
// Shared types and default widths for the prescaled counter and its prescaler.
package prescaled_counter_pkg;

  localparam int DEFAULT_COUNTER_WIDTH  = 24;
  localparam int DEFAULT_PRESCALE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prescaled_counter_prescaler_tick.sv
// Runtime-programmable prescaler: hit fires every prescale_limit+1 cycles while run is high.
module prescaler_tick
  import prescaled_counter_pkg::*;
#(
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] prescale_limit,
  output logic                      hit
);

  logic [PRESCALE_WIDTH-1:0] prescaler;

  // >= rather than == so a limit lowered below the running value still hits promptly.
  assign hit = run && !clear && (prescaler >= prescale_limit);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (clear || !run || hit) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// Prescaled up/down timer with top value, load, one-shot/auto-reload and compare match.
// Optional PWM output enabled by defining PRESCALED_COUNTER_PWM_EN.
module prescaled_counter
  import prescaled_counter_pkg::*;
#(
  parameter int COUNTER_WIDTH  = DEFAULT_COUNTER_WIDTH,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      one_shot,
  input  logic                      up_down,
  input  logic [PRESCALE_WIDTH-1:0] prescale_limit,
  input  logic [COUNTER_WIDTH-1:0]  top,
  input  logic                      load,
  input  logic [COUNTER_WIDTH-1:0]  load_value,
  input  logic [COUNTER_WIDTH-1:0]  compare,
  output logic [COUNTER_WIDTH-1:0]  count,
  output logic                      tick,
  output logic                      wrap,
  output logic                      done,
  output logic                      cmp_match
`ifdef PRESCALED_COUNTER_PWM_EN
  ,
  output logic                      pwm_out
`endif
);

  state_t                     state, state_next;
  logic [COUNTER_WIDTH-1:0]   count_next;
  logic                       tick_next, wrap_next;
  logic                       run, hit, terminal;

  assign run = (state == RUN) && en;

  prescaler_tick #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .clk            (clk),
    .rst            (rst),
    .clear          (load),
    .run            (run),
    .prescale_limit (prescale_limit),
    .hit            (hit)
  );

  // Up terminal uses >= so a loaded value above top ends at the next step.
  assign terminal = up_down ? (count >= top) : (count == '0);

  // NOTE: every signal gets a default first so this block cannot infer latches.
  always_comb begin
    state_next = state;
    count_next = count;
    tick_next  = 1'b0;
    wrap_next  = 1'b0;
    if (load) begin
      state_next = IDLE;
      count_next = load_value;
    end else begin
      case (state)
        IDLE: if (en) state_next = RUN;
        RUN: begin
          if (!en) begin
            state_next = IDLE;
          end else if (hit) begin
            tick_next = 1'b1;
            if (terminal) begin
              wrap_next = 1'b1;
              if (one_shot) state_next = DONE;
              else          count_next = up_down ? '0 : top;
            end else begin
              count_next = up_down ? count + COUNTER_WIDTH'(1) : count - COUNTER_WIDTH'(1);
            end
          end
        end
        DONE: if (!en) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
      done      <= 1'b0;
      cmp_match <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      tick      <= tick_next;
      wrap      <= wrap_next;
      done      <= (state_next == DONE);
      cmp_match <= (count_next == compare);
    end
  end

`ifdef PRESCALED_COUNTER_PWM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_out <= 1'b0;
    else     pwm_out <= (state_next != IDLE) && (count_next < compare);
  end
`endif

endmodule

// File: tb/tb_prescaled_counter.sv
// Randomised self-checking bench for prescaled_counter against a cycle-level behavioural model.
module tb_prescaled_counter;

  localparam int CW = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst, en, one_shot, up_down, load;
  logic [PW-1:0] prescale_limit;
  logic [CW-1:0] top, load_value, compare;
  logic [CW-1:0] count;
  logic          tick, wrap, done, cmp_match;
`ifdef PRESCALED_COUNTER_PWM_EN
  logic          pwm_out;
`endif

  prescaled_counter #(.COUNTER_WIDTH(CW), .PRESCALE_WIDTH(PW)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .one_shot       (one_shot),
    .up_down        (up_down),
    .prescale_limit (prescale_limit),
    .top            (top),
    .load           (load),
    .load_value     (load_value),
    .compare        (compare),
    .count          (count),
    .tick           (tick),
    .wrap           (wrap),
    .done           (done),
    .cmp_match      (cmp_match)
`ifdef PRESCALED_COUNTER_PWM_EN
    ,
    .pwm_out        (pwm_out)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = stopped, 1 = running, 2 = finished one-shot.
  int m_mode, m_count, m_pre;
  bit m_tick, m_wrap, m_done, m_cmp, m_pwm;

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_pre = 0;
    m_tick = 0; m_wrap = 0; m_done = 0; m_cmp = 0; m_pwm = 0;
  endtask

  task automatic model_step();
    int nc = m_count;
    int nm = m_mode;
    int np = 0;
    bit t  = 0;
    bit w  = 0;
    if (load) begin
      nc = int'(load_value);
      nm = 0;
    end else if (m_mode == 0) begin
      if (en) nm = 1;
    end else if (m_mode == 1) begin
      if (!en) begin
        nm = 0;
      end else if (m_pre >= int'(prescale_limit)) begin
        t = 1;
        if (up_down) begin
          if (m_count < int'(top)) nc = m_count + 1;
          else begin w = 1; if (one_shot) nm = 2; else nc = 0; end
        end else begin
          if (m_count > 0) nc = m_count - 1;
          else begin w = 1; if (one_shot) nm = 2; else nc = int'(top); end
        end
      end else begin
        np = m_pre + 1;
      end
    end else begin
      if (!en) nm = 0;
    end
    m_mode = nm; m_count = nc; m_pre = np;
    m_tick = t; m_wrap = w;
    m_done = (nm == 2);
    m_cmp  = (nc == int'(compare));
    m_pwm  = (nm != 0) && (nc < int'(compare));
  endtask

  // Compare process: outputs settle at posedge, checked at negedge, then model advances.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      check("count", 32'(count), 32'(m_count));
      check("tick", 32'(tick), 32'(m_tick));
      check("wrap", 32'(wrap), 32'(m_wrap));
      check("done", 32'(done), 32'(m_done));
      check("cmp_match", 32'(cmp_match), 32'(m_cmp));
`ifdef PRESCALED_COUNTER_PWM_EN
      check("pwm_out", 32'(pwm_out), 32'(m_pwm));
`endif
      if (!rst) model_step();
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int gap);
    bit ok = 0;
    gap = 0;
    repeat (40) begin
      next_cycle();
      gap++;
      if (tick) begin ok = 1; break; end
    end
    if (!ok) check("tick_timeout", 32'(0), 32'(1));
  endtask

  task automatic load_idle(input logic [CW-1:0] v);
    en = 0; load = 1; load_value = v;
    next_cycle();
    load = 0;
  endtask

  initial begin
    int gap;
    bit seen;
    rst = 1; en = 0; one_shot = 0; up_down = 1; load = 0;
    prescale_limit = '0; top = 8'd9; load_value = '0; compare = 8'hFF;
    next_cycle(); next_cycle();
    check("rst_count", 32'(count), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_cmp", 32'(cmp_match), 32'(0));
    rst = 0;

    // Period of 7 cycles, wrap 9->0 on the 10th tick, then a lowered limit.
    prescale_limit = 4'd6; top = 8'd9; up_down = 1; one_shot = 0;
    load_idle(8'd0);
    en = 1;
    wait_tick(gap);
    check("first_tick_gap", 32'(gap), 32'(8));
    check("first_tick_count", 32'(count), 32'(1));
    for (int i = 2; i <= 10; i++) begin
      wait_tick(gap);
      check("tick_period", 32'(gap), 32'(7));
      check("tick_wrap", 32'(wrap), 32'(i == 10));
    end
    check("wrap_count", 32'(count), 32'(0));
    next_cycle(); next_cycle(); next_cycle();
    prescale_limit = 4'd2;
    next_cycle();
    check("lowered_limit_tick", 32'(tick), 32'(1));
    check("lowered_limit_count", 32'(count), 32'(1));
    wait_tick(gap);
    check("lowered_period", 32'(gap), 32'(3));

    // Down one-shot from 3.
    prescale_limit = '0; up_down = 0; one_shot = 1;
    load_idle(8'd3);
    check("os_load", 32'(count), 32'(3));
    en = 1;
    next_cycle(); check("os_start", 32'(count), 32'(3));
    next_cycle(); check("os_2", 32'(count), 32'(2));
    next_cycle(); check("os_1", 32'(count), 32'(1));
    next_cycle(); check("os_0", 32'(count), 32'(0));
    check("os_0_nowrap", 32'(wrap), 32'(0));
    next_cycle();
    check("os_wrap", 32'(wrap), 32'(1));
    check("os_done", 32'(done), 32'(1));
    check("os_hold", 32'(count), 32'(0));
    next_cycle();
    check("os_done_held", 32'(done), 32'(1));
    check("os_no_tick", 32'(tick), 32'(0));
    en = 0;
    next_cycle();
    check("os_done_clear", 32'(done), 32'(0));

    // Load coincident with a hit at count 4; load above top wraps next step.
    up_down = 1; one_shot = 0; top = 8'd9;
    load_idle(8'd0);
    en = 1;
    seen = 0;
    repeat (20) begin
      next_cycle();
      if (count == 8'd4) begin seen = 1; break; end
    end
    check("reach_4", 32'(seen), 32'(1));
    load = 1; load_value = 8'd100;
    next_cycle();
    load = 0;
    check("load_count", 32'(count), 32'(100));
    check("load_tick", 32'(tick), 32'(0));
    check("load_wrap", 32'(wrap), 32'(0));
    next_cycle();
    next_cycle();
    check("above_top_count", 32'(count), 32'(0));
    check("above_top_wrap", 32'(wrap), 32'(1));

    // Compare match at 7 with top 15.
    top = 8'd15; compare = 8'd7;
    load_idle(8'd0);
    check("cmp_idle", 32'(cmp_match), 32'(0));
`ifdef PRESCALED_COUNTER_PWM_EN
    check("pwm_idle", 32'(pwm_out), 32'(0));
`endif
    en = 1;
    next_cycle();
    for (int k = 1; k <= 15; k++) begin
      next_cycle();
      check("cmp_count", 32'(count), 32'(k));
      check("cmp_match_k", 32'(cmp_match), 32'(k == 7));
`ifdef PRESCALED_COUNTER_PWM_EN
      check("pwm_k", 32'(pwm_out), 32'(k < 7));
`endif
    end

    // Natural wrap at all ones, then down reload from 0.
    top = 8'hFF; compare = 8'hFF;
    load_idle(8'd250);
    en = 1;
    next_cycle();
    for (int k = 251; k <= 255; k++) begin
      next_cycle();
      check("nat_count", 32'(count), 32'(k));
    end
    next_cycle();
    check("nat_wrap_count", 32'(count), 32'(0));
    check("nat_wrap", 32'(wrap), 32'(1));
    top = 8'd5; up_down = 0;
    load_idle(8'd0);
    en = 1;
    next_cycle();
    next_cycle();
    check("down_reload", 32'(count), 32'(5));
    check("down_reload_wrap", 32'(wrap), 32'(1));

    // Asynchronous reset mid-run at count 5.
    top = 8'd9; up_down = 1;
    seen = 0;
    repeat (20) begin
      next_cycle();
      if (count == 8'd5) begin seen = 1; break; end
    end
    check("reach_5", 32'(seen), 32'(1));
    #2 rst = 1;
    #1;
    check("async_count", 32'(count), 32'(0));
    check("async_done", 32'(done), 32'(0));
    check("async_tick", 32'(tick), 32'(0));
    next_cycle();
    rst = 0;
    next_cycle();
    check("post_rst_idle", 32'(count), 32'(0));
    next_cycle();
    check("post_rst_run", 32'(count), 32'(1));

    // Randomised phase.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rst  = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 19) == 0);
      en   = ($urandom_range(0, 15) != 0);
      load_value = ($urandom_range(0, 7) == 0) ? CW'($urandom) : CW'($urandom_range(0, 40));
      if ($urandom_range(0, 63) == 0) one_shot = ~one_shot;
      if ($urandom_range(0, 31) == 0) up_down = ~up_down;
      if ($urandom_range(0, 15) == 0) prescale_limit = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) top = ($urandom_range(0, 7) == 0) ? 8'hFF : CW'($urandom_range(0, 30));
      if ($urandom_range(0, 31) == 0) compare = CW'($urandom_range(0, 30));
    end
    rst = 0;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
